// File: rtl/sdram_req_frontend_if.sv
// User request/response and controller command bundle for sdram_req_frontend.
interface sdram_req_frontend_if #(
    parameter int AW = 25,
    parameter int DW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic [1:0]    mc_cmd;
    logic [AW-1:0] mc_addr;
    logic          mc_ready;
    logic [DW-1:0] mc_wdata;
    logic [DW-1:0] mc_rdata;
    logic          mc_valid;
    logic          init_done;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rsp_ready, mc_rdata, mc_valid,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output mc_cmd, mc_addr, mc_ready, mc_wdata, init_done
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output rsp_ready, mc_rdata, mc_valid,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  mc_cmd, mc_addr, mc_ready, mc_wdata, init_done
    );
endinterface

// File: rtl/sdram_req_frontend.sv
// SDRAM request front end: request FIFO, single-outstanding issue FSM.
// Optional WAIT timeout abort enabled by SDRAM_REQ_TIMEOUT_EN.
module sdram_req_frontend #(
    parameter int DEPTH   = 4,
    parameter int AW      = 25,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_req_frontend_if.slave  bus
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int EW = AW + DW + 1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_n;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic          timeout, is_wr;

    logic          init_q;
    logic [1:0]    cmd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rsp_valid_q, rsp_write_q;
    logic [DW-1:0] rsp_rdata_q;

    // MSB differs with equal index bits means the write pointer lapped once
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PW-2:0]];
    assign push  = bus.req_valid && bus.req_ready;
    assign pop   = (state == RESP) && bus.rsp_ready;
    assign is_wr = (cmd_q == 2'b10);

    assign bus.req_ready = !full && init_q;
    assign bus.init_done = init_q;
    assign bus.mc_ready  = (state == ISSUE);
    assign bus.mc_cmd    = cmd_q;
    assign bus.mc_addr   = addr_q;
    assign bus.mc_wdata  = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef SDRAM_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
    end

    assign timeout = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));

    // a completion in the same cycle as the timeout is a normal response
    always_ff @(posedge clk) begin
        if (rst)                                    err_q <= 1'b0;
        else if (timeout && !bus.mc_valid)          err_q <= 1'b1;
        else if (pop)                               err_q <= 1'b0;
    end

    assign bus.rsp_err = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-2:0]] <= {bus.req_write, bus.req_addr, bus.req_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            INIT:    if (bus.mc_valid) state_n = IDLE;
            IDLE:    if (!empty) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (bus.mc_valid || timeout) state_n = RESP;
            RESP:    if (bus.rsp_ready) state_n = IDLE;
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q      <= 1'b0;
            cmd_q       <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (state == INIT && bus.mc_valid) init_q <= 1'b1;
            if (state == IDLE && !empty) begin
                cmd_q   <= head[EW-1] ? 2'b10 : 2'b01;
                addr_q  <= head[EW-2:DW];
                wdata_q <= head[DW-1:0];
            end
            if (state == WAIT && (bus.mc_valid || timeout)) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= is_wr;
                rsp_rdata_q <= (bus.mc_valid && !is_wr) ? bus.mc_rdata : '0;
            end
            if (pop) begin
                rsp_valid_q <= 1'b0;
                cmd_q       <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_sdram_req_frontend.sv
// Directed bench for sdram_req_frontend with a small controller model.
// Timeout checks apply when SDRAM_REQ_TIMEOUT_EN is defined.
module tb_sdram_req_frontend;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_req_frontend_if #(.AW(AW), .DW(DW)) bus ();

    sdram_req_frontend #(
        .DEPTH(4), .AW(AW), .DW(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          init_req_n = 0;
    int          init_ack_n = 0;
    int          lat_cnt    = 0;
    int          ctl_lat    = 4;
    int          n_issue    = 0;
    bit          ctl_fixed  = 1'b0;
    bit          ctl_hold   = 1'b0;
    logic [15:0] ctl_rdata  = 16'h0;
    logic [15:0] rd_val     = 16'h0;

    int            stab_bad  = 0;
    int            extra_rdy = 0;
    bit            in_wait   = 1'b0;
    logic [1:0]    s_cmd;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;

    // reads return a pattern of the address unless a fixed value is chosen
    logic          t_wr   [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0};
    logic [AW-1:0] t_addr [10] = '{'h0000A01, 'h0000B02, 'h0000C03, 'h0000D04, 'h0000E05,
                                   'h0001F06, 'h0002007, 'h0003008, 'h0004009, 'h000500A};
    logic [DW-1:0] t_wd   [10] = '{'h0A0A, 'hB0B0, 'h0C0C, 'hD0D0, 'h0E0E,
                                   'h0F0F, 'h2020, 'h3030, 'h4040, 'h5555};
    logic [DW-1:0] t_rd   [10] = '{'hF5FE, 'h0000, 'hF3FC, 'h0000, 'hF1FA,
                                   'hE0F9, 'h0000, 'hCFF7, 'h0000, 'hAFF5};

    initial begin : ctl_model
        bus.mc_valid = 1'b0;
        bus.mc_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mc_valid = 1'b0;
            if (init_ack_n != init_req_n) begin
                init_ack_n   = init_req_n;
                bus.mc_valid = 1'b1;
            end else if (!bus.init_done) begin
                lat_cnt = 0;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.mc_valid = 1'b1;
                    bus.mc_rdata = rd_val;
                end
            end else if (bus.mc_ready) begin
                n_issue++;
                if (!ctl_hold) begin
                    rd_val  = ctl_fixed ? ctl_rdata : ~bus.mc_addr[15:0];
                    lat_cnt = ctl_lat;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!bus.init_done) begin
                in_wait = 1'b0;
            end else if (bus.mc_ready) begin
                if (in_wait || bus.rsp_valid) extra_rdy++;
                in_wait = 1'b1;
                s_cmd   = bus.mc_cmd;
                s_addr  = bus.mc_addr;
                s_wd    = bus.mc_wdata;
            end else if (in_wait) begin
                if (bus.mc_cmd != s_cmd || bus.mc_addr != s_addr || bus.mc_wdata != s_wd)
                    stab_bad++;
                if (bus.rsp_valid) in_wait = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        ok            = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.req_ready) ok = 1'b1;
            else               @(negedge clk);
        end
        if (!ok) check("push_timeout", 0, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.mc_ready) ok = 1'b1;
            else              @(negedge clk);
        end
        if (!ok) check({tag, "_issue_timeout"}, 0, 1);
    endtask

    task automatic wait_rsp(input string tag, input logic w, input logic [DW-1:0] rd,
                            input logic err);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.rsp_valid) ok = 1'b1;
            else               @(negedge clk);
        end
        check({tag, "_valid"}, 32'(ok), 1);
        if (ok) begin
            check({tag, "_write"}, 32'(bus.rsp_write), 32'(w));
            check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(rd));
            check({tag, "_err"},   32'(bus.rsp_err),   32'(err));
        end
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic w, input logic [DW-1:0] rd);
        wait_rsp(tag, w, rd, 1'b0);
        ack();
    endtask

    initial begin : stim
        int bad;
        int n0;
        int cyc;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        check("rst_mc_cmd",    32'(bus.mc_cmd),    0);
        check("rst_mc_addr",   32'(bus.mc_addr),   0);
        check("rst_mc_ready",  32'(bus.mc_ready),  0);
        check("rst_init_done", 32'(bus.init_done), 0);

        rst           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 'h123;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.req_ready || bus.mc_ready) bad++;
        end
        check("init_gate", 32'(bad), 0);
        bus.req_valid = 1'b0;
        @(posedge clk);
        init_req_n++;
        @(negedge clk);
        check("init_pre", 32'(bus.init_done), 0);
        @(negedge clk);
        check("init_done", 32'(bus.init_done), 1);
        check("init_ready", 32'(bus.req_ready), 1);

        ctl_fixed = 1'b1;
        ctl_rdata = 16'hBEEF;
        n0 = n_issue;
        push(1'b0, 'h1ABCDEF, 'h0);
        wait_issue("rd");
        @(negedge clk);
        check("rd_cmd",   32'(bus.mc_cmd),   1);
        check("rd_addr",  32'(bus.mc_addr),  'h1ABCDEF);
        check("rd_pulse", 32'(bus.mc_ready), 0);
        get_rsp("rd", 1'b0, 16'hBEEF);
        check("rd_issues", 32'(n_issue - n0), 1);

        ctl_fixed = 1'b0;
        push(1'b1, 'h0000010, 'h1234);
        wait_issue("wr");
        @(negedge clk);
        check("wr_cmd",   32'(bus.mc_cmd),   2);
        check("wr_wdata", 32'(bus.mc_wdata), 'h1234);
        get_rsp("wr", 1'b1, 16'h0000);

        n0 = n_issue;
        push(1'b1, 'h0000100, 'h1111);
        push(1'b0, 'h0000200, 'h0);
        push(1'b1, 'h0000300, 'h3333);
        push(1'b0, 'h1000400, 'h0);
        check("bp_full", 32'(bus.req_ready), 0);
        get_rsp("bp0", 1'b1, 16'h0000);
        check("bp0_issues", 32'(n_issue - n0), 1);
        get_rsp("bp1", 1'b0, 16'hFDFF);
        check("bp1_issues", 32'(n_issue - n0), 2);
        get_rsp("bp2", 1'b1, 16'h0000);
        check("bp2_issues", 32'(n_issue - n0), 3);
        get_rsp("bp3", 1'b0, 16'hFBFF);
        check("bp3_issues", 32'(n_issue - n0), 4);

        push(t_wr[0], t_addr[0], t_wd[0]);
        push(t_wr[1], t_addr[1], t_wd[1]);
        wait_rsp("pp0", t_wr[0], t_rd[0], 1'b0);
        check("pp_ready", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_write = t_wr[2];
        bus.req_addr  = t_addr[2];
        bus.req_wdata = t_wd[2];
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        push(t_wr[3], t_addr[3], t_wd[3]);
        check("pp_count3", 32'(bus.req_ready), 1);
        push(t_wr[4], t_addr[4], t_wd[4]);
        check("pp_full", 32'(bus.req_ready), 0);
        for (int k = 1; k < 5; k++) get_rsp($sformatf("pp%0d", k), t_wr[k], t_rd[k]);
        for (int k = 5; k < 9; k++) push(t_wr[k], t_addr[k], t_wd[k]);
        check("wrap_full", 32'(bus.req_ready), 0);
        get_rsp("wrap5", t_wr[5], t_rd[5]);
        push(t_wr[9], t_addr[9], t_wd[9]);
        for (int k = 6; k < 10; k++) get_rsp($sformatf("wrap%0d", k), t_wr[k], t_rd[k]);

        check("stable_wait", 32'(stab_bad), 0);
        check("one_pulse",   32'(extra_rdy), 0);

        ctl_hold = 1'b1;
        push(1'b0, 'h0000777, 'h7777);
        wait_issue("mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rsp_valid", 32'(bus.rsp_valid), 0);
        check("mid_rsp_rdata", 32'(bus.rsp_rdata), 0);
        check("mid_mc_cmd",    32'(bus.mc_cmd),    0);
        check("mid_mc_addr",   32'(bus.mc_addr),   0);
        check("mid_mc_wdata",  32'(bus.mc_wdata),  0);
        check("mid_mc_ready",  32'(bus.mc_ready),  0);
        check("mid_req_ready", 32'(bus.req_ready), 0);
        check("mid_init_done", 32'(bus.init_done), 0);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mc_ready) bad++;
        end
        check("mid_no_rsp", 32'(bad), 0);
        @(posedge clk);
        init_req_n++;
        repeat (2) @(negedge clk);
        check("reinit_done", 32'(bus.init_done), 1);

        push(1'b0, 'h0000888, 'h0);
        wait_issue("to");
        cyc = 0;
        while (!bus.rsp_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
`ifdef SDRAM_REQ_TIMEOUT_EN
        check("to_cycles", 32'(cyc), TO + 1);
        check("to_err",    32'(bus.rsp_err),   1);
        check("to_rdata",  32'(bus.rsp_rdata), 0);
        ack();
        check("to_cleared", 32'(bus.rsp_valid), 0);
`else
        check("no_to_valid", 32'(bus.rsp_valid), 0);
        check("no_to_err",   32'(bus.rsp_err),   0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_req_frontend.md
Name: sdram_req_frontend

Overview:
- Upstream stage of the SDRAM memory controller.
- Accepts read and write requests from user logic over a valid/ready handshake and buffers them in a small FIFO.
- Issues requests to the controller one at a time via its cmd/addr/ready/valid interface, holding them stable until completion.
- Returns one response per request, carrying read data for reads.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, 2..16.
- AW, 25, request address width; matches the controller address ({bank[1:0], row[12:0], col[9:0]}).
- DW, 16, data width.
- TIMEOUT, 64, cycles to wait for mc_valid before abort (optional feature only).

Ports:
- clk  in  1  system clock, same clock as the controller.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of the request type.
- rsp_rdata  out  DW  read data; 0 for writes.
- rsp_err  out  1  timeout abort flag (optional feature only; otherwise tied to 0).
- mc_cmd  out  2  controller command: 01 = READ, 10 = WRITE, 00 = none.
- mc_addr  out  AW  controller address.
- mc_ready  out  1  command strobe to the controller.
- mc_wdata  out  DW  write data to the controller.
- mc_rdata  in  DW  read data from the controller.
- mc_valid  in  1  controller completion / init-done pulse.
- init_done  out  1  controller initialisation seen.

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0.
  - mc_cmd=00, mc_addr=0, mc_ready=0, mc_wdata=0, init_done=0.
  - FIFO empty; state=INIT.
- FIFO:
  - Push when req_valid && req_ready.
  - req_ready = !full && init_done.
  - Pointers are log2(DEPTH)+1 bits wide and wrap naturally; full/empty are decided by the pointer MSB compare.
  - Push while full is impossible because req_ready=0.
  - Pop happens in RESP on handshake; a push and a pop in the same cycle are both performed and the count is unchanged.
- State machine:
  - INIT: waits for the first mc_valid (the controller pulses it once at the end of its init sequence). On that pulse set init_done=1 (sticky until rst) and go to IDLE. mc_ready=0 throughout.
  - IDLE: if FIFO not empty, load the head entry into output registers (mc_cmd = write ? 10 : 01, mc_addr, mc_wdata) and go to ISSUE.
  - ISSUE: mc_ready=1 for exactly one cycle, then go to WAIT.
  - WAIT: mc_ready=0. mc_cmd, mc_addr and mc_wdata are held stable, because the controller samples addr combinationally over several states and steers DQ direction from cmd. On mc_valid=1, capture mc_rdata into rsp_rdata if the request is a read (0 if a write), set rsp_write, set rsp_valid=1, and go to RESP.
  - RESP: hold the response until rsp_ready. On handshake: rsp_valid=0, pop the FIFO, mc_cmd=00, go to IDLE.
  - Minimum latency from the request being at the FIFO head to rsp_valid is 3 cycles plus controller latency.
- mc_valid is ignored in IDLE, ISSUE and RESP.
- The next request is never issued before the previous response has been accepted; there is strictly one outstanding request.
- rst asserted mid-operation returns to INIT and clears the FIFO and init_done. The controller is reset by the same rst and re-pulses valid after its init.

Optional Feature:
- Macro: SDRAM_REQ_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mc_valid: rsp_valid=1, rsp_err=1, rsp_rdata=0, go to RESP; the request is popped normally on handshake.
  - mc_valid in the same cycle as the timeout wins: normal response, rsp_err=0.
- Disabled: no counter; WAIT waits indefinitely; rsp_err is constant 0.

Test Plan:
- Init gating: drive req_valid=1 from reset with mc_valid low for 20 cycles -> req_ready=0 and mc_ready=0 throughout; pulse mc_valid -> init_done=1 next cycle, req_ready=1.
- Single read: read addr 0x1ABCDEF, controller model returns 0xBEEF with mc_valid 4 cycles after mc_ready -> one mc_ready pulse, mc_cmd=01 and mc_addr=0x1ABCDEF stable through WAIT, rsp_valid with rsp_rdata=0xBEEF, rsp_write=0.
- Single write: write 0x0000010 / 0x1234 -> mc_cmd=10, mc_wdata=0x1234 held until mc_valid; response rsp_write=1, rsp_rdata=0.
- Full/backpressure: push 4 requests with rsp_ready=0 -> req_ready=0 after the 4th; release rsp_ready -> responses in order W,R,W,R, each preceded by exactly one mc_ready pulse.
- Simultaneous push/pop: with FIFO count 2, push in the same cycle as the RESP handshake -> count stays 2; all pointers wrap past DEPTH with correct ordering over 10 requests.
- Reset mid-WAIT: assert rst for one cycle during WAIT -> all outputs at reset values next cycle, state INIT, prior rsp never emitted. With SDRAM_REQ_TIMEOUT_EN and TIMEOUT=8, withhold mc_valid -> rsp_err=1 exactly 8 cycles into WAIT.
